// File: rtl/tt_um_8bit_alu.sv
// Registered 8-bit ALU for TinyTapeout: operands loaded serially into A/B,
// EXEC writes result R and Z/C/V/N flags one clock later.
module tt_um_8bit_alu (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_LOADA = 2'b01,
        CMD_LOADB = 2'b10,
        CMD_EXEC  = 2'b11
    } cmd_e;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_SAR = 4'hA;
    localparam logic [3:0] OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC;
    localparam logic [3:0] OP_INC = 4'hD;
    localparam logic [3:0] OP_DEC = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    logic [DW-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic          z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;

    cmd_e          cmd;
    logic [3:0]    op;
    logic          cin;
    logic [DW:0]   add_ext, sub_ext;
    logic          v_add, v_sub;
    logic [DW-1:0] res;
    logic          c_new, v_new, write_r;
    logic          unused_ok;

    assign cmd       = cmd_e'(uio_in[5:4]);
    assign op        = uio_in[3:0];
    assign unused_ok = &{1'b0, uio_in[7:6]};

    // Shared adder/subtractor; carry-in only for ADC/SBB, taken from the held C flag
    always_comb begin
        cin     = ((op == OP_ADC) || (op == OP_SBB)) ? c_q : 1'b0;
        add_ext = {1'b0, a_q} + {1'b0, b_q} + {{DW{1'b0}}, cin};
        sub_ext = {1'b0, a_q} - {1'b0, b_q} - {{DW{1'b0}}, cin};
        v_add   = (a_q[DW-1] == b_q[DW-1]) && (add_ext[DW-1] != a_q[DW-1]);
        v_sub   = (a_q[DW-1] != b_q[DW-1]) && (sub_ext[DW-1] != a_q[DW-1]);
    end

    always_comb begin
        res     = '0;
        c_new   = 1'b0;
        v_new   = 1'b0;
        write_r = 1'b1;
        case (op)
            OP_ADD, OP_ADC: begin
                res   = add_ext[DW-1:0];
                c_new = add_ext[DW];
                v_new = v_add;
            end
            OP_SUB, OP_SBB: begin
                res   = sub_ext[DW-1:0];
                c_new = sub_ext[DW];
                v_new = v_sub;
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOT: res = ~a_q;
            OP_SHL: begin
                res   = {a_q[DW-2:0], 1'b0};
                c_new = a_q[DW-1];
            end
            OP_SHR: begin
                res   = {1'b0, a_q[DW-1:1]};
                c_new = a_q[0];
            end
            OP_SAR: begin
                res   = {a_q[DW-1], a_q[DW-1:1]};
                c_new = a_q[0];
            end
            OP_ROL: begin
                res   = {a_q[DW-2:0], a_q[DW-1]};
                c_new = a_q[DW-1];
            end
            OP_ROR: begin
                res   = {a_q[0], a_q[DW-1:1]};
                c_new = a_q[0];
            end
            OP_INC: begin
                res   = a_q + DW'(1);
                c_new = (a_q == 8'hFF);
                v_new = (a_q == 8'h7F);
            end
            OP_DEC: begin
                res   = a_q - DW'(1);
                c_new = (a_q == 8'h00);
                v_new = (a_q == 8'h80);
            end
            default: begin
                // CMP: subtract for flags only, R keeps its value
                res     = sub_ext[DW-1:0];
                c_new   = sub_ext[DW];
                v_new   = v_sub;
                write_r = 1'b0;
            end
        endcase
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        z_d = z_q;
        c_d = c_q;
        v_d = v_q;
        n_d = n_q;
        if (ena) begin
            case (cmd)
                CMD_LOADA: a_d = ui_in;
                CMD_LOADB: b_d = ui_in;
                CMD_EXEC: begin
                    if (write_r) begin
                        r_d = res;
                    end
                    z_d = (res == '0);
                    c_d = c_new;
                    v_d = v_new;
                    n_d = res[DW-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
            z_q <= 1'b0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            z_q <= z_d;
            c_q <= c_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign uo_out  = r_q;
    assign uio_out = {z_q, c_q, v_q, n_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_8bit_alu.sv
// Directed bench for tt_um_8bit_alu; expected outputs are queued by the
// stimulus and compared by an independent monitor one clock later.
module tb_tt_um_8bit_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_8bit_alu dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         step;
        logic [7:0] r;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t sb_q[$];
    exp_t armed;
    logic armed_v = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    localparam logic [1:0] NOP = 2'b00, LDA = 2'b01, LDB = 2'b10, EXE = 2'b11;

    // Arm the entry for the command captured at this edge
    always @(posedge clk) begin
        if (sb_q.size() > 0) begin
            armed   = sb_q.pop_front();
            armed_v = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed_v) begin
            total++;
            if ({uo_out, uio_out, uio_oe} !== {armed.r, armed.uio, armed.oe}) begin
                bad++;
                $display("FAIL step%0d: got R=%h uio_out=%h uio_oe=%h, want R=%h uio_out=%h uio_oe=%h",
                         armed.step, uo_out, uio_out, uio_oe, armed.r, armed.uio, armed.oe);
            end
            armed_v = 1'b0;
        end
    end

    // flags argument is {Z,C,V,N}
    task automatic do_cmd(input logic rst, input logic en, input logic [1:0] cmd,
                          input logic [3:0] op, input logic [7:0] d,
                          input logic [7:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        ena    = en;
        ui_in  = d;
        uio_in = {2'($urandom), cmd, op};
        step++;
        e.step = step;
        e.r    = er;
        e.uio  = {ef, 4'h0};
        e.oe   = 8'hF0;
        sb_q.push_back(e);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset held with random traffic
        for (int i = 0; i < 4; i++)
            do_cmd(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), 8'h00, 4'b0000);
        do_cmd(1'b1, 1'b1, NOP, 4'h0, 8'h5A, 8'h00, 4'b0000);

        // Add overflow and carry-out
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h7F, 8'h00, 4'b0000);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h01, 8'h00, 4'b0000);
        do_cmd(1'b1, 1'b1, EXE, 4'h0, 8'h00, 8'h80, 4'b0011);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'hFF, 8'h80, 4'b0011);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h01, 8'h80, 4'b0011);
        do_cmd(1'b1, 1'b1, EXE, 4'h0, 8'h00, 8'h00, 4'b1100);

        // Borrow chain: SUB then SBB consuming the borrow
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h00, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h01, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, EXE, 4'h1, 8'h00, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h05, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h02, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, EXE, 4'h3, 8'h00, 8'h02, 4'b0000);

        // Logic and shifts on A=A5, B=0F
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'hA5, 8'h02, 4'b0000);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h0F, 8'h02, 4'b0000);
        do_cmd(1'b1, 1'b1, EXE, 4'h4, 8'h00, 8'h05, 4'b0000);
        do_cmd(1'b1, 1'b1, EXE, 4'h6, 8'h00, 8'hAA, 4'b0001);
        do_cmd(1'b1, 1'b1, EXE, 4'h8, 8'h00, 8'h4A, 4'b0100);
        do_cmd(1'b1, 1'b1, EXE, 4'hA, 8'h00, 8'hD2, 4'b0101);
        do_cmd(1'b1, 1'b1, EXE, 4'hC, 8'h00, 8'hD2, 4'b0101);
        do_cmd(1'b1, 1'b1, EXE, 4'h6, 8'h00, 8'hAA, 4'b0001);

        // CMP leaves R alone
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h10, 8'hAA, 4'b0001);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h10, 8'hAA, 4'b0001);
        do_cmd(1'b1, 1'b1, EXE, 4'hF, 8'h00, 8'hAA, 4'b1000);

        // ena gating
        do_cmd(1'b1, 1'b0, LDA, 4'h0, 8'h33, 8'hAA, 4'b1000);
        do_cmd(1'b1, 1'b0, EXE, 4'h7, 8'h00, 8'hAA, 4'b1000);
        do_cmd(1'b1, 1'b1, EXE, 4'h7, 8'h00, 8'hEF, 4'b0001);

        // INC/DEC boundaries
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h7F, 8'hEF, 4'b0001);
        do_cmd(1'b1, 1'b1, EXE, 4'hD, 8'h00, 8'h80, 4'b0011);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'hFF, 8'h80, 4'b0011);
        do_cmd(1'b1, 1'b1, EXE, 4'hD, 8'h00, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h00, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, EXE, 4'hE, 8'h00, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h80, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, EXE, 4'hE, 8'h00, 8'h7F, 4'b0010);

        // ADC with carry in, rotates/shift right, SBB with borrow in, OR
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'hFF, 8'h7F, 4'b0010);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h01, 8'h7F, 4'b0010);
        do_cmd(1'b1, 1'b1, EXE, 4'h0, 8'h00, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h10, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h20, 8'h00, 4'b1100);
        do_cmd(1'b1, 1'b1, EXE, 4'h2, 8'h00, 8'h31, 4'b0000);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h81, 8'h31, 4'b0000);
        do_cmd(1'b1, 1'b1, EXE, 4'hB, 8'h00, 8'h03, 4'b0100);
        do_cmd(1'b1, 1'b1, EXE, 4'h9, 8'h00, 8'h40, 4'b0100);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h00, 8'h40, 4'b0100);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h00, 8'h40, 4'b0100);
        do_cmd(1'b1, 1'b1, EXE, 4'h3, 8'h00, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h50, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, LDB, 4'h0, 8'h0A, 8'hFF, 4'b0101);
        do_cmd(1'b1, 1'b1, EXE, 4'h5, 8'h00, 8'h5A, 4'b0000);

        // Asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        #2;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        #1;
        total++;
        if ({uo_out, uio_out, uio_oe} !== 24'h0000F0) begin
            bad++;
            $display("FAIL async_reset: got R=%h uio_out=%h uio_oe=%h, want R=00 uio_out=00 uio_oe=F0",
                     uo_out, uio_out, uio_oe);
        end
        do_cmd(1'b0, 1'b1, EXE, 4'h0, 8'h00, 8'h00, 4'b0000);
        do_cmd(1'b1, 1'b1, LDA, 4'h0, 8'h3C, 8'h00, 4'b0000);
        do_cmd(1'b1, 1'b1, EXE, 4'h2, 8'h00, 8'h3C, 4'b0000);
        do_cmd(1'b1, 1'b1, NOP, 4'h0, 8'h00, 8'h3C, 4'b0000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !armed_v) break;
        end
        if (sb_q.size() != 0 || armed_v) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries pending, want 0", sb_q.size() + int'(armed_v));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_8bit_alu.md
# tt_um_8bit_alu

- Registered 8-bit ALU packaged as a TinyTapeout user project.
- Operands are loaded serially from the dedicated input bus into two internal registers.
- An execute command applies one of 16 operations; the result appears on the dedicated outputs and four status flags on the upper bidirectional pins.
- The block is the top level of the user design and sits directly under the TinyTapeout harness.

## Interface
- No parameters.
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design-selected; when 0, all registers hold (reset still acts).
- ui_in  input  8  operand data bus.
- uio_in  input  8  control: [3:0] opcode, [5:4] command, [7:6] ignored.
- uo_out  output  8  result register R.
- uio_out  output  8  [7]=Z, [6]=C, [5]=V, [4]=N flag registers; [3:0] driven 0.
- uio_oe  output  8  constant 8'hF0 (upper nibble output, lower nibble input), including during reset.

## Operation
- State: A[7:0], B[7:0], R[7:0], flags Z,C,V,N. All clear to 0 on rst_n=0.
- Command uio_in[5:4], acted on at rising clk when ena=1:
  - 00 NOP: everything holds.
  - 01 LOADA: A <= ui_in.
  - 10 LOADB: B <= ui_in.
  - 11 EXEC: R and flags updated from the current A, B, C and opcode uio_in[3:0].
- Opcodes (res = 8-bit result):
  - 0 ADD: A+B. C=carry-out. V=signed overflow.
  - 1 SUB: A-B. C=borrow (1 iff A<B unsigned). V=signed overflow.
  - 2 ADC: A+B+C. C=carry-out. V=signed overflow.
  - 3 SBB: A-B-C. C=borrow (1 iff A < B+C unsigned). V=signed overflow.
  - 4 AND, 5 OR, 6 XOR: A op B. C=0, V=0.
  - 7 NOT: ~A. C=0, V=0.
  - 8 SHL: {A[6:0],0}. C=A[7].
  - 9 SHR: {0,A[7:1]}. C=A[0].
  - A SAR: {A[7],A[7:1]}. C=A[0].
  - B ROL: {A[6:0],A[7]}. C=A[7].
  - C ROR: {A[0],A[7:1]}. C=A[0].
  - D INC: A+1. C=carry-out. V=(A==8'h7F).
  - E DEC: A-1. C=borrow (A==0). V=(A==8'h80).
  - F CMP: flags computed exactly as SUB; R holds its previous value.
- Shift and rotate opcodes (8-C) always set V=0.
- Z = (res==0) and N = res[7] for every EXEC. For CMP, Z and N use the A-B difference.
- Signed overflow for add: operands share a sign and the result sign differs. For subtract: operand signs differ and the result sign differs from A.
- ADC/SBB use the C flag value held before the edge.
- Arithmetic wraps modulo 256.

## Timing
- Latency: one clock. R and flags are valid immediately after the EXEC edge and hold until the next EXEC.
- LOADA/LOADB take effect at the edge. An EXEC in the following cycle sees the new value; no bypass within a cycle.
- Only one command per cycle, so load and execute never collide.
- ena=0 on an edge: the command is ignored and all registers hold.
- Reset asserted mid-sequence: A, B, R and flags go to 0 immediately and asynchronously; uo_out=0, uio_out=0.
- Deassertion of reset is sampled by the next rising clk.
- No combinational path from inputs to uo_out or uio_out. uio_oe is constant.

## Test plan
- Reset: hold rst_n=0, drive random ui_in/uio_in -> uo_out=00, uio_out=00, uio_oe=F0. Release; NOP -> outputs unchanged.
- Add overflow: LOADA 7F, LOADB 01, EXEC op0 -> R=80, N=1, V=1, C=0, Z=0. Then LOADA FF, LOADB 01, EXEC op0 -> R=00, Z=1, C=1, V=0.
- Borrow chain: LOADA 00, LOADB 01, EXEC op1 -> R=FF, C=1, N=1. Then LOADA 05, LOADB 02, EXEC op3 -> R=02, C=0.
- Logic and shifts, with A=A5, B=0F:
  - op4 -> R=05, C=0, V=0.
  - op6 -> R=AA.
  - op8 -> R=4A, C=1.
  - opA -> R=D2, C=1.
  - opC -> R=D2, C=1.
- CMP and hold: after R=AA, LOADA 10, LOADB 10, EXEC opF -> R stays AA, Z=1, C=0.
- ena gating: set ena=0, issue LOADA 33 then EXEC op7 -> outputs unchanged. Set ena=1, EXEC op7 -> R equals ~A using the old A, not 33.
